// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC TDM serializer: state encoding,
// midscale code and two's-complement to offset-binary conversion.
package dac_pkg;

    // Widest sample the helpers handle; callers cast results down to DATA_W.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STARVE = 2'd2
    } dac_state_t;

    // Code that represents 0 after conversion.
    function automatic logic [MAX_W-1:0] mid_code(input int data_w, input bit offset_binary);
        logic [MAX_W-1:0] m;
        m = '0;
        if (offset_binary) begin
            m[data_w-1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] conv(input logic [MAX_W-1:0] x, input int data_w,
                                              input bit offset_binary);
        return x ^ mid_code(data_w, offset_binary);
    endfunction

endpackage

// File: rtl/dac_tdm_serializer_if.sv
// Frame stream from the baseband sample source into the serializer.
interface dac_tdm_serializer_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 2
);
    logic                     s_valid;
    logic                     s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dac_frame_fifo.sv
// Single-clock first-word-fall-through frame FIFO; dout is valid while !empty.
module dac_frame_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level_reg == (PTR_W+1)'(DEPTH));
    assign empty = (level_reg == '0);
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr_reg];
    assign level = level_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: rtl/dac_tdm_serializer.sv
// Frame-buffered TDM serializer: pops one multi-channel frame per frame slot
// and emits its channels one per clk on a registered DAC bus.
module dac_tdm_serializer
    import dac_pkg::*;
#(
    parameter int DATA_W        = 12,
    parameter int NUM_CH        = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    dac_tdm_serializer_if.slave           s_bus,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_frame,
    output logic                          dac_valid,
    output logic                          underflow,
    output logic [15:0]                   underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int                CH_W    = $clog2(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
    localparam bit                OB      = (OFFSET_BINARY != 0);
    localparam logic [DATA_W-1:0] MID     = DATA_W'(mid_code(DATA_W, OB));

    logic [NUM_CH*DATA_W-1:0] fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;

    dac_frame_fifo #(
        .WIDTH (NUM_CH*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_bus.s_valid),
        .pop   (fifo_pop),
        .din   (s_bus.s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign s_bus.s_ready = !fifo_full;

    dac_state_t        state_reg, state_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic [DATA_W-1:0] holding_reg [NUM_CH];
    logic [DATA_W-1:0] fifo_ch [NUM_CH];
    logic [DATA_W-1:0] conv_ch [NUM_CH];
    logic [DATA_W-1:0] dac_data_reg, dac_data_next;
    logic              dac_frame_reg, dac_frame_next;
    logic              dac_valid_reg, dac_valid_next;
    logic              underflow_reg, underflow_next;
    logic [15:0]       underflow_count_reg, underflow_count_next;
    logic              boundary;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign fifo_ch[gi] = fifo_dout[gi*DATA_W +: DATA_W];
        assign conv_ch[gi] = DATA_W'(conv(MAX_W'(holding_reg[gi]), DATA_W, OB));
    end

    // Every decision (pop, starve, stop) is taken only at a frame boundary,
    // so the output never leaves a frame half-sent.
    always_comb begin
        boundary   = (state_reg == ST_IDLE) || (ch_reg == LAST_CH);
        state_next = state_reg;
        ch_next    = ch_reg + CH_W'(1);
        fifo_pop   = 1'b0;
        if (boundary) begin
            ch_next = '0;
            if (!enable) begin
                state_next = ST_IDLE;
            end else if (!fifo_empty) begin
                state_next = ST_RUN;
                fifo_pop   = 1'b1;
            end else if (state_reg != ST_IDLE) begin
                state_next = ST_STARVE;
            end
        end
    end

    always_comb begin
        dac_data_next  = MID;
        dac_valid_next = 1'b0;
        dac_frame_next = 1'b0;
        if (state_reg == ST_RUN) begin
            dac_data_next  = conv_ch[ch_reg];
            dac_valid_next = 1'b1;
            dac_frame_next = (ch_reg == '0);
        end
        // Pulse lines up with the first midscale word of each starved slot.
        underflow_next       = (state_reg == ST_STARVE) && (ch_reg == '0);
        underflow_count_next = underflow_count_reg;
        if (underflow_next && (underflow_count_reg != 16'hFFFF)) begin
            underflow_count_next = underflow_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            ch_reg              <= '0;
            holding_reg         <= '{default: '0};
            dac_data_reg        <= MID;
            dac_frame_reg       <= 1'b0;
            dac_valid_reg       <= 1'b0;
            underflow_reg       <= 1'b0;
            underflow_count_reg <= '0;
        end else begin
            state_reg           <= state_next;
            ch_reg              <= ch_next;
            if (fifo_pop) begin
                holding_reg <= fifo_ch;
            end
            dac_data_reg        <= dac_data_next;
            dac_frame_reg       <= dac_frame_next;
            dac_valid_reg       <= dac_valid_next;
            underflow_reg       <= underflow_next;
            underflow_count_reg <= underflow_count_next;
        end
    end

    assign dac_data        = dac_data_reg;
    assign dac_frame       = dac_frame_reg;
    assign dac_valid       = dac_valid_reg;
    assign underflow       = underflow_reg;
    assign underflow_count = underflow_count_reg;
endmodule

// File: tb/tb_dac_tdm_serializer.sv
// Directed bench for dac_tdm_serializer: three parameterisations (2ch/12b offset
// binary, 4ch/12b, 3ch/16b pass-through) driven from vector tables and sequences.
module tb_dac_tdm_serializer;
    import dac_pkg::*;

    logic clk;
    logic reset;
    logic enable_a, enable_b, enable_c;

    dac_tdm_serializer_if #(.DATA_W(12), .NUM_CH(2)) bus_a ();
    dac_tdm_serializer_if #(.DATA_W(12), .NUM_CH(4)) bus_b ();
    dac_tdm_serializer_if #(.DATA_W(16), .NUM_CH(3)) bus_c ();

    logic [11:0] data_a, data_b;
    logic [15:0] data_c;
    logic        frame_a, frame_b, frame_c;
    logic        valid_a, valid_b, valid_c;
    logic        uf_a, uf_b, uf_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [3:0]  lvl_a, lvl_b;
    logic [2:0]  lvl_c;

    dac_tdm_serializer #(.DATA_W(12), .NUM_CH(2), .FIFO_DEPTH(8), .OFFSET_BINARY(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .s_bus(bus_a),
        .dac_data(data_a), .dac_frame(frame_a), .dac_valid(valid_a), .underflow(uf_a),
        .underflow_count(cnt_a), .fifo_level(lvl_a));

    dac_tdm_serializer #(.DATA_W(12), .NUM_CH(4), .FIFO_DEPTH(8), .OFFSET_BINARY(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .s_bus(bus_b),
        .dac_data(data_b), .dac_frame(frame_b), .dac_valid(valid_b), .underflow(uf_b),
        .underflow_count(cnt_b), .fifo_level(lvl_b));

    dac_tdm_serializer #(.DATA_W(16), .NUM_CH(3), .FIFO_DEPTH(4), .OFFSET_BINARY(0)) dut_c (
        .clk(clk), .reset(reset), .enable(enable_c), .s_bus(bus_c),
        .dac_data(data_c), .dac_frame(frame_c), .dac_valid(valid_c), .underflow(uf_c),
        .underflow_count(cnt_c), .fifo_level(lvl_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] frame;
        logic [11:0] exp0;
        logic [11:0] exp1;
    } vec_t;

    vec_t        vecs [5];
    logic [47:0] frames_b [3];
    logic [11:0] exp_b [12];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] burst_frame(input int k);
        logic [11:0] c0, c1;
        c0 = 12'(k * 149 + 7);
        c1 = 12'(4000 - k * 61);
        return {c1, c0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [23:0] fr;
        logic [11:0] samp;
        logic [11:0] exp_w;
        logic        rdy;
        logic [3:0]  lvl;
        int          w;
        bit          started;
        bit          saw_full;

        vecs[0] = '{24'h123_7FF, 12'hFFF, 12'h923};
        vecs[1] = '{24'h000_800, 12'h000, 12'h800};
        vecs[2] = '{24'hFFF_001, 12'h801, 12'h7FF};
        vecs[3] = '{24'h5A5_A5A, 12'h25A, 12'hDA5};
        vecs[4] = '{24'h400_C00, 12'h400, 12'hC00};

        frames_b[0] = {12'h7A3, 12'hF02, 12'h801, 12'h100};
        frames_b[1] = {12'hFFF, 12'h0FF, 12'h811, 12'h010};
        frames_b[2] = {12'h000, 12'h800, 12'hAAA, 12'h555};
        exp_b = '{12'h900, 12'h001, 12'h702, 12'hFA3,
                  12'h810, 12'h011, 12'h8FF, 12'h7FF,
                  12'hD55, 12'h2AA, 12'h000, 12'h800};

        reset = 1'b0;
        enable_a = 1'b0; enable_b = 1'b0; enable_c = 1'b0;
        bus_a.s_valid = 1'b0; bus_a.s_data = '0;
        bus_b.s_valid = 1'b0; bus_b.s_data = '0;
        bus_c.s_valid = 1'b0; bus_c.s_data = '0;
        step();

        // Reset state
        do_reset();
        check("rst_data",   32'(data_a),        32'h800);
        check("rst_frame",  32'(frame_a),       32'd0);
        check("rst_valid",  32'(valid_a),       32'd0);
        check("rst_uf",     32'(uf_a),          32'd0);
        check("rst_count",  32'(cnt_a),         32'd0);
        check("rst_ready",  32'(bus_a.s_ready), 32'd1);
        check("rst_level",  32'(lvl_a),         32'd0);
        check("rst_data_c", 32'(data_c),        32'h0000);
        $display("reset state checked");

        // Table vectors: one frame from IDLE, exact two-edge latency
        for (int v = 0; v < 5; v++) begin
            do_reset();
            enable_a = 1'b1;
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = vecs[v].frame;
            step();
            bus_a.s_valid = 1'b0;
            check("vec_lat_t0", 32'(valid_a), 32'd0);
            step();
            check("vec_lat_t1", 32'(valid_a), 32'd0);
            step();
            check("vec_ch0",       32'(data_a),  32'(vecs[v].exp0));
            check("vec_ch0_frame", 32'(frame_a), 32'd1);
            check("vec_ch0_valid", 32'(valid_a), 32'd1);
            step();
            check("vec_ch1",       32'(data_a),  32'(vecs[v].exp1));
            check("vec_ch1_frame", 32'(frame_a), 32'd0);
            $display("vec %0d frame=0x%06h ch0=0x%03h ch1=0x%03h", v, vecs[v].frame,
                     vecs[v].exp0, vecs[v].exp1);
        end

        // Single frame, then sustained starvation and counter saturation
        do_reset();
        enable_a = 1'b1;
        bus_a.s_valid = 1'b1;
        bus_a.s_data  = 24'h123_7FF;
        step();
        bus_a.s_valid = 1'b0;
        check("sf_level", 32'(lvl_a), 32'd1);
        step();
        step();
        check("sf_ch0",   32'(data_a),  32'hFFF);
        check("sf_frame", 32'(frame_a), 32'd1);
        step();
        check("sf_ch1",    32'(data_a), 32'h923);
        check("sf_ch1_uf", 32'(uf_a),   32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("starve_uf", 32'(uf_a), 32'((k % 2) == 0));
            if ((k % 2) == 0) begin
                check("starve_count", 32'(cnt_a),   32'(k / 2 + 1));
                check("starve_mid",   32'(data_a),  32'h800);
                check("starve_valid", 32'(valid_a), 32'd0);
            end
        end
        $display("starvation: 3 slots, count=%0d", cnt_a);
        force dut_a.underflow_count_reg = 16'hFFFE;
        #1;
        release dut_a.underflow_count_reg;
        step();
        check("sat_uf",    32'(uf_a),  32'd1);
        check("sat_count", 32'(cnt_a), 32'hFFFF);
        step();
        step();
        check("sat_uf2",    32'(uf_a),  32'd1);
        check("sat_count2", 32'(cnt_a), 32'hFFFF);
        $display("saturation: count=0x%04h", cnt_a);

        // Asynchronous reset in the middle of a stream
        for (int f = 0; f < 3; f++) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = vecs[f].frame;
            step();
        end
        bus_a.s_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !valid_a; cyc++) step();
        check("ar_streaming", 32'(valid_a), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("ar_data",  32'(data_a),        32'h800);
        check("ar_frame", 32'(frame_a),       32'd0);
        check("ar_valid", 32'(valid_a),       32'd0);
        check("ar_level", 32'(lvl_a),         32'd0);
        check("ar_count", 32'(cnt_a),         32'd0);
        check("ar_ready", 32'(bus_a.s_ready), 32'd1);
        step();
        #3;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("ar_post_valid", 32'(valid_a), 32'd0);
            check("ar_post_uf",    32'(uf_a),    32'd0);
        end
        $display("async reset mid-stream: outputs quiet after release");

        // Burst of 20 frames with s_valid held high
        do_reset();
        enable_a = 1'b1;
        w = 0; started = 1'b0; saw_full = 1'b0;
        begin
            int idx;
            idx = 0;
            bus_a.s_valid = 1'b1;
            bus_a.s_data  = burst_frame(0);
            for (int cyc = 0; cyc < 200 && w < 40; cyc++) begin
                rdy = bus_a.s_ready;
                lvl = lvl_a;
                check("burst_ready", 32'(rdy), 32'(lvl != 4'd8));
                if (lvl == 4'd8) saw_full = 1'b1;
                step();
                if (rdy && bus_a.s_valid) begin
                    idx++;
                    if (idx == 20) bus_a.s_valid = 1'b0;
                    else bus_a.s_data = burst_frame(idx);
                end
                if (valid_a) begin
                    fr    = burst_frame(w / 2);
                    samp  = ((w % 2) == 0) ? fr[11:0] : fr[23:12];
                    exp_w = samp ^ 12'h800;
                    check("burst_word",  32'(data_a),  32'(exp_w));
                    check("burst_frame", 32'(frame_a), 32'((w % 2) == 0));
                    check("burst_uf",    32'(uf_a),    32'd0);
                    w++;
                    started = 1'b1;
                end else if (started && w < 40) begin
                    check("burst_gap", 32'(valid_a), 32'd1);
                end
            end
        end
        check("burst_words",     32'(w),        32'd40);
        check("burst_full_seen", 32'(saw_full), 32'd1);
        $display("burst: %0d words streamed", w);
        enable_a = 1'b0;

        // NUM_CH=4: enable dropped mid-frame, resume from FIFO
        do_reset();
        check("b_rst_data", 32'(data_b), 32'h800);
        enable_b = 1'b1;
        for (int f = 0; f < 3; f++) begin
            bus_b.s_valid = 1'b1;
            bus_b.s_data  = frames_b[f];
            step();
        end
        bus_b.s_valid = 1'b0;
        w = 0;
        for (int cyc = 0; cyc < 40 && w < 8; cyc++) begin
            if (valid_b) begin
                check("b_word",  32'(data_b),  32'(exp_b[w]));
                check("b_frame", 32'(frame_b), 32'((w % 4) == 0));
                w++;
                if (w == 6) enable_b = 1'b0;
            end
            if (w < 8) step();
        end
        check("b_words_before_stop", 32'(w), 32'd8);
        step();
        check("b_stop_valid", 32'(valid_b),         32'd0);
        check("b_stop_state", 32'(dut_b.state_reg), 32'(ST_IDLE));
        check("b_stop_data",  32'(data_b),          32'h800);
        for (int k = 0; k < 3; k++) begin
            step();
            check("b_idle_valid", 32'(valid_b), 32'd0);
            check("b_idle_uf",    32'(uf_b),    32'd0);
        end
        check("b_idle_level", 32'(lvl_b), 32'd1);
        enable_b = 1'b1;
        for (int cyc = 0; cyc < 20 && w < 12; cyc++) begin
            step();
            if (valid_b) begin
                check("b_resume_word",  32'(data_b),  32'(exp_b[w]));
                check("b_resume_frame", 32'(frame_b), 32'((w % 4) == 0));
                w++;
            end
        end
        check("b_resume_words", 32'(w), 32'd12);
        $display("4ch: enable drop/resume, %0d words", w);
        enable_b = 1'b0;

        // DATA_W=16, NUM_CH=3, pass-through
        do_reset();
        check("c_idle_data", 32'(data_c), 32'h0000);
        enable_c = 1'b1;
        bus_c.s_valid = 1'b1;
        bus_c.s_data  = {16'hFFFF, 16'h0001, 16'h8000};
        step();
        bus_c.s_valid = 1'b0;
        step();
        step();
        check("c_ch0",       32'(data_c),  32'h8000);
        check("c_ch0_frame", 32'(frame_c), 32'd1);
        step();
        check("c_ch1",       32'(data_c),  32'h0001);
        check("c_ch1_frame", 32'(frame_c), 32'd0);
        step();
        check("c_ch2",       32'(data_c),  32'hFFFF);
        step();
        check("c_starve_data",  32'(data_c),  32'h0000);
        check("c_starve_valid", 32'(valid_c), 32'd0);
        check("c_starve_uf",    32'(uf_c),    32'd1);
        $display("3ch/16b pass-through frame checked");
        enable_c = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_tdm_serializer.md
Name: dac_tdm_serializer

Overview:
Parametrised DAC sample serializer. It accepts multi-channel sample frames over a valid/ready stream, buffers them in an internal FIFO, and time-division multiplexes the channels onto one DAC data bus, one channel per clk cycle, with a frame marker. It adds format conversion, underflow detection and counting, and frame-aligned enable. It sits between the baseband sample source and the DAC I/O primitive stage, replacing the fixed 2-channel 12-bit I/Q path.

Parameters:
DATA_W, 12, sample width in bits (>=2)
NUM_CH, 2, channels per frame (>=2); channel 0 is sent first
FIFO_DEPTH, 8, frame FIFO depth; power of two, >=2
OFFSET_BINARY, 1, 1 = invert the MSB of every sample at output (two's complement to offset binary); 0 = pass through

Ports:
clk  in  1  sample clock; the only clock
reset  in  1  asynchronous, active-high reset
enable  in  1  streaming enable; sampled at frame boundaries
s_valid  in  1  input frame valid
s_ready  out  1  input frame ready; equals !fifo_full
s_data  in  NUM_CH*DATA_W  frame; channel k is bits [k*DATA_W +: DATA_W], two's complement
dac_data  out  DATA_W  registered DAC word
dac_frame  out  1  high during the channel-0 slot of a real frame
dac_valid  out  1  high while dac_data carries real samples
underflow  out  1  one-cycle pulse per starved frame slot
underflow_count  out  16  starved-frame counter; saturates at 0xFFFF
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous) forces the following values. FIFO is empty. State is IDLE and the channel counter is 0. dac_data = MID. MID is the midscale code: 0 after conversion, i.e. 0x800 when OFFSET_BINARY=1 and 0x000 when OFFSET_BINARY=0. dac_frame, dac_valid and underflow are 0. underflow_count = 0. s_ready = 1.
- Reset mid-frame discards the partial frame and all FIFO contents.
- FIFO push occurs when s_valid && s_ready. A push is refused when full, even if a pop happens in the same cycle.
- A pop in the same cycle as a push is legal when the FIFO is neither empty nor full. fifo_level is then unchanged.
- The FIFO is written at its write pointer. The pointer wraps modulo FIFO_DEPTH. The extra level bit distinguishes full from empty.
- A frame boundary is any cycle in IDLE, or the cycle where the channel counter = NUM_CH-1.
- State machine (IDLE, RUN, STARVE), evaluated at each frame boundary:
  - !enable: go to IDLE. Output MID with dac_valid=0. The FIFO keeps its contents.
  - enable && FIFO not empty: pop one frame into the holding register and go to RUN.
  - enable && FIFO empty: from RUN or STARVE, go to STARVE and pulse underflow. From IDLE, stay in IDLE with no underflow.
- Channel counter:
  - Counts 0..NUM_CH-1 and wraps while in RUN or STARVE.
  - Held at 0 in IDLE.
  - Enable deasserted mid-frame takes effect only after channel NUM_CH-1 is output.
- Output is registered:
  - In RUN, dac_data = conv(holding[ch]), dac_valid = 1, and dac_frame = (ch == 0).
  - In STARVE and IDLE, dac_data = MID and dac_valid = dac_frame = 0.
  - STARVE slots are a full NUM_CH cycles long, so resumption is frame-aligned.
- Latency: with an empty FIFO, enable=1 and state IDLE, a frame accepted at edge t gives ch0 on dac_data after edge t+2. Channels 1..NUM_CH-1 follow on consecutive edges.
- Back-to-back frames stream with no gap when the FIFO is never empty at a boundary.
- underflow_count increments on each underflow pulse and holds at 0xFFFF. It is cleared only by reset.
- conv(x) = {x[MSB] ^ OFFSET_BINARY, x[MSB-1:0]}.

Decomposition:
- Shared package dac_pkg holds:
  - function mid_code(DATA_W, OFFSET_BINARY)
  - function conv
  - state encoding localparams ST_IDLE, ST_RUN, ST_STARVE
- One sub-module: dac_frame_fifo, a synchronous single-clock FIFO parametrised by WIDTH and DEPTH.
  - Ports: clk, reset, push, pop, din, dout, full, empty, level.
  - dout is valid while !empty (first-word fall-through).
- The top level contains the FSM, the channel counter, the holding register, conversion and the output registers.

Test Plan:
- Single frame, defaults: reset, enable=1, push {q=0x123, i=0x7FF}. dac_data = 0xFFF (ch0, dac_frame=1) after edge t+2, then 0x923 (ch1). Next slot: underflow pulse, count = 1, dac_data = 0x800.
- Burst of 20 frames with s_valid held high. Requirements:
  - s_ready drops when fifo_level = 8.
  - Output is continuous, with dac_frame every 2 cycles.
  - No underflow occurs.
  - All 40 words are in order.
- Enable dropped mid-frame with NUM_CH=4: channels 1..3 of the current frame still complete. Next cycle dac_valid = 0 and the state is IDLE. Remaining FIFO frames resume with ch0 after re-enable.
- OFFSET_BINARY=0, DATA_W=16, NUM_CH=3: samples 0x8000, 0x0001, 0xFFFF are emitted unchanged. Idle output is 0x0000.
- Reset asserted asynchronously mid-stream (not on a clock edge):
  - Outputs immediately go to MID, dac_frame = 0, fifo_level = 0, underflow_count = 0.
  - Nothing stale is emitted after release.
- Sustained starvation with enable=1 and no input for 3*NUM_CH cycles after one frame: exactly 3 underflow pulses, spaced NUM_CH cycles apart. Force the count to 0xFFFE and confirm it saturates at 0xFFFF.
